// File: rtl/code_decoder_fifo_pkg.sv
// Shared widths and the code-to-one-hot helper for the buffered 3-to-8 decoder.
package code_dec_pkg;
  localparam int IN_W  = 3;
  localparam int OUT_W = 8;

  function automatic logic [OUT_W-1:0] onehot_dec(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] word;
    word       = '0;
    word[code] = 1'b1;
    return word;
  endfunction
endpackage

// File: rtl/code_decoder_fifo_if.sv
// Code-in / one-hot-out handshake bundle for code_decoder_fifo.
interface code_decoder_fifo_if;
  import code_dec_pkg::*;

  // Handshake rule for both channels: a transfer happens on a rising edge
  // exactly when valid && ready are both 1. A producer holding valid=1 with
  // ready=0 keeps its data stable; ready never waits on valid.
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  Din;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Dout;

  modport slave (
    input  in_valid, Din, out_ready,
    output in_ready, out_valid, Dout
  );

  modport master (
    output in_valid, Din, out_ready,
    input  in_ready, out_valid, Dout
  );
endinterface

// File: rtl/code_decoder_fifo_fifo.sv
// First-word-fall-through code FIFO: head is visible the cycle after the write.
module code_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately unreset; the top gates the head with valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/code_decoder_fifo.sv
// Buffered 3-to-8 one-hot decoder: FIFO of codes, en masks the output side as a stall.
module code_decoder_fifo
  import code_dec_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  code_decoder_fifo_if.slave    bus,
  output logic [CNT_W-1:0]      count
);
  logic            full;
  logic            empty;
  logic [IN_W-1:0] head;
  logic            in_ready;
  logic            out_valid;

  assign in_ready      = !full;
  // en stalls the output: no valid, so no pop, and the head stays put.
  assign out_valid     = !empty && !en;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.Dout      = out_valid ? onehot_dec(head) : '0;

  code_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid && in_ready),
    .pop   (out_valid && bus.out_ready),
    .din   (bus.Din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_code_decoder_fifo.sv
// Bench for code_decoder_fifo: directed scenarios plus random traffic against a queue model.
module tb_code_decoder_fifo;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] count;
  int         checks;
  int         errors;
  logic [7:0] exp_q[$];

  code_decoder_fifo_if dif();

  code_decoder_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (dif),
    .count (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: inputs are stable from posedge+1 to the next posedge,
  // so the transfer that the coming edge performs is decided here.
  always @(negedge clk) begin
    logic exp_valid;
    logic will_push;
    logic will_pop;
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", dif.out_valid, 0);
      check("rst_dout", dif.Dout, 0);
      check("rst_count", count, 0);
    end else begin
      exp_valid = (exp_q.size() != 0) && !en;
      check("mon_in_ready", dif.in_ready, exp_q.size() != DEPTH);
      check("mon_out_valid", dif.out_valid, exp_valid);
      check("mon_dout", dif.Dout, exp_valid ? exp_q[0] : 8'h00);
      check("mon_count", count, exp_q.size());
      will_push = dif.in_valid && (exp_q.size() < DEPTH);
      will_pop  = exp_valid && dif.out_ready;
      if (will_pop) void'(exp_q.pop_front());
      if (will_push) exp_q.push_back(8'd1 << dif.Din);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_code(input logic [2:0] c);
    dif.in_valid = 1'b1;
    dif.Din      = c;
    step();
    dif.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    dif.out_ready = 1'b1;
    repeat (n) step();
    dif.out_ready = 1'b0;
  endtask

  logic [7:0] drain_seq [4];
  logic       rdy;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    en = 1'b0;
    dif.in_valid = 1'b0;
    dif.Din = '0;
    dif.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("post_reset_in_ready", dif.in_ready, 1);
    check("post_reset_count", count, 0);

    // 1: single push of 5
    push_code(3'd5);
    check("t1_out_valid", dif.out_valid, 1);
    check("t1_dout", dif.Dout, 8'h20);
    check("t1_count", count, 1);
    drain(1);
    check("t1_empty", count, 0);

    // 2: fill, rejected fifth push, ordered drain
    push_code(3'd0); push_code(3'd1); push_code(3'd2); push_code(3'd7);
    check("t2_count_full", count, 4);
    check("t2_in_ready", dif.in_ready, 0);
    push_code(3'd3);
    check("t2_count_after_reject", count, 4);
    drain_seq[0] = 8'h01; drain_seq[1] = 8'h02; drain_seq[2] = 8'h04; drain_seq[3] = 8'h80;
    dif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_dout", dif.Dout, drain_seq[i]);
      step();
    end
    dif.out_ready = 1'b0;
    check("t2_out_valid_empty", dif.out_valid, 0);
    check("t2_dout_empty", dif.Dout, 0);

    // 3: streaming at count=2 across pointer wrap
    push_code(3'd0); push_code(3'd1);
    dif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dif.in_valid = 1'b1;
      dif.Din = 3'(i);
      step();
      check("t3_count_steady", count, 2);
    end
    dif.in_valid = 1'b0;
    check("t3_dout_after_wrap", dif.Dout, 8'h10);
    drain(2);

    // 4: en stall freezes head 4
    push_code(3'd4);
    en = 1'b1;
    dif.out_ready = 1'b1;
    repeat (3) begin
      #1;
      check("t4_stall_dout", dif.Dout, 0);
      step();
      check("t4_stall_count", count, 1);
    end
    en = 1'b0;
    #1;
    check("t4_resume_dout", dif.Dout, 8'h10);
    step();
    dif.out_ready = 1'b0;
    check("t4_popped", count, 0);

    // 5: full with push and pop together
    push_code(3'd6); push_code(3'd1); push_code(3'd3); push_code(3'd2);
    dif.in_valid = 1'b1;
    dif.Din = 3'd5;
    dif.out_ready = 1'b1;
    step();
    dif.in_valid = 1'b0;
    check("t5_count", count, 3);
    check("t5_in_ready", dif.in_ready, 1);

    // 6: async reset mid-drain
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", dif.out_valid, 0);
    check("t6_dout", dif.Dout, 0);
    check("t6_count", count, 0);
    dif.out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    push_code(3'd6);
    check("t6_first_push", dif.Dout, 8'h40);
    drain(1);

    // random traffic; a stalled producer holds its code
    rdy = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(dif.in_valid && !rdy)) begin
        dif.in_valid = ($urandom_range(0, 2) != 0);
        dif.Din = 3'($urandom_range(0, 7));
      end
      dif.out_ready = ($urandom_range(0, 2) != 0);
      en = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      rdy = dif.in_ready;
      step();
    end
    dif.in_valid = 1'b0;
    en = 1'b0;
    drain(DEPTH + 2);
    check("final_empty", count, 0);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
